// File: rtl/uart_recv_cfg.sv
// UART receiver with configurable data width, parity and stop bits.
// The line is sampled at mid-bit; the result is published with a one-cycle done pulse.
module uart_recv_cfg #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  output logic                 uart_done,
  output logic [DATA_BITS-1:0] uart_data,
  output logic                 rx_flag,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = (BPS_CNT < 2) ? 1 : $clog2(BPS_CNT);
  localparam logic [CW-1:0] MID  = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (BPS_CNT < 2) begin : g_bad_bps
      $error("uart_recv_cfg: CLK_FREQ/UART_BPS must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_recv_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_recv_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_recv_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rxd_m, rxd_s, rxd_d;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad, stop_bad;
  logic                 at_mid, at_end, exp_par;

  assign at_mid  = (clk_cnt == MID);
  assign at_end  = (clk_cnt == LAST);
  assign exp_par = (^shift) ^ (PARITY == 1);
  assign rx_flag = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rxd_d && !rxd_s) state_nxt = START;
      START: if (at_mid && rxd_s) state_nxt = IDLE;
             else if (at_end)     state_nxt = DATA;
      DATA:  if (at_end && bit_cnt == DATA_LAST)
               state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:   if (at_end) state_nxt = STOP;
      // Leave at the final stop sample so a following start edge is never missed.
      STOP:  if (at_mid && bit_cnt == STOP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_m      <= 1'b1;
      rxd_s      <= 1'b1;
      rxd_d      <= 1'b1;
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      uart_done  <= 1'b0;
      uart_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxd_m     <= uart_rxd;
      rxd_s     <= rxd_m;
      rxd_d     <= rxd_s;
      state     <= state_nxt;
      uart_done <= 1'b0;

      if (state == IDLE || state_nxt == IDLE || at_end) clk_cnt <= '0;
      else                                              clk_cnt <= clk_cnt + CW'(1);

      if (state_nxt != state) bit_cnt <= '0;
      else if (at_end)        bit_cnt <= bit_cnt + 4'd1;

      if (state == IDLE && state_nxt == START) begin
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end

      if (at_mid) begin
        case (state)
          DATA: shift <= {rxd_s, shift[DATA_BITS-1:1]};
          PAR:  par_bad <= rxd_s ^ exp_par;
          STOP: begin
            if (bit_cnt == STOP_LAST) begin
              uart_done  <= 1'b1;
              uart_data  <= shift;
              parity_err <= par_bad;
              frame_err  <= stop_bad | ~rxd_s;
            end else begin
              stop_bad <= stop_bad | ~rxd_s;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_recv_cfg.sv
// Bench for uart_recv_cfg: four receivers (8N1, 8E1, 8N2, 8O2) at 16 clocks per bit,
// directed spec cases plus random frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_recv_cfg;

  localparam int BPS = 16;
  localparam int ND  = 4;

  typedef struct {
    int         d;
    int         cyc;
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       flag;
  } evt_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [ND-1:0]       rxd = '1;
  logic [ND-1:0]       done, flag, pe, fe;
  logic [ND-1:0][7:0]  dout;
  int                  cyc = 0;
  int                  vectors = 0;
  int                  miscompares = 0;
  logic [7:0]          last_data [ND];
  evt_t                evq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_recv_cfg #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[0]), .uart_done(done[0]),
    .uart_data(dout[0]), .rx_flag(flag[0]), .parity_err(pe[0]), .frame_err(fe[0]));
  uart_recv_cfg #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[1]), .uart_done(done[1]),
    .uart_data(dout[1]), .rx_flag(flag[1]), .parity_err(pe[1]), .frame_err(fe[1]));
  uart_recv_cfg #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[2]), .uart_done(done[2]),
    .uart_data(dout[2]), .rx_flag(flag[2]), .parity_err(pe[2]), .frame_err(fe[2]));
  uart_recv_cfg #(.CLK_FREQ(16), .UART_BPS(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_8o2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[3]), .uart_done(done[3]),
    .uart_data(dout[3]), .rx_flag(flag[3]), .parity_err(pe[3]), .frame_err(fe[3]));

  function automatic int par_mode(input int d);
    case (d)
      1:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int nstop(input int d);
    return (d >= 2) ? 2 : 1;
  endfunction

  // Log every done pulse with the cycle it was seen in.
  always @(negedge clk) begin
    evt_t e;
    for (int d = 0; d < ND; d++) begin
      if (done[d] === 1'b1) begin
        e.d = d; e.cyc = cyc; e.data = dout[d]; e.pe = pe[d]; e.fe = fe[d]; e.flag = flag[d];
        evq.push_back(e);
      end
    end
  end

  task automatic take(input int d, output logic found, output evt_t e);
    found = 1'b0;
    e = '{default: 0};
    for (int i = 0; i < evq.size(); i++) begin
      if (evq[i].d == d) begin
        e = evq[i];
        evq.delete(i);
        found = 1'b1;
        break;
      end
    end
  endtask

  function automatic int pending(input int d);
    int n = 0;
    foreach (evq[i]) if (evq[i].d == d) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if ({done[d], flag[d], pe[d], fe[d], dout[d]} !== 12'h0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: done=%b flag=%b pe=%b fe=%b data=%h, expected all 0",
                 d, done[d], flag[d], pe[d], fe[d], dout[d]);
      end
      last_data[d] = 8'h00;
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Send one frame on line d and check the published result against the frame model.
  task automatic test_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops, input int idle);
    logic bits[$];
    int   fall, exp_cyc, ones;
    logic exp_pe, exp_fe, got;
    evt_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (par_mode(d) != 0) bits.push_back(pbit);
    for (int s = 0; s < nstop(d); s++) bits.push_back(stops[s]);
    ones = $countones(data);
    if (par_mode(d) == 0)      exp_pe = 1'b0;
    else if (par_mode(d) == 2) exp_pe = (pbit != ones[0]);
    else                       exp_pe = (pbit == ones[0]);
    exp_fe = !stops[0] || (nstop(d) == 2 && !stops[1]);
    // 2 sync flops, 1 edge detect, mid-sample of the final stop bit, then 1 to register.
    exp_cyc = cyc + 3 + (bits.size() - 1) * BPS + BPS / 2 + 1;
    fall = cyc;
    foreach (bits[i]) begin
      rxd[d] = bits[i];
      repeat (BPS) @(negedge clk);
    end
    rxd[d] = 1'b1;
    repeat (idle) @(negedge clk);

    take(d, got, e);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL frame_done dut%0d data=%h: no uart_done pulse, expected one", d, data);
    end else begin
      vectors++;
      if (e.cyc !== exp_cyc) begin
        miscompares++;
        $display("FAIL frame_timing dut%0d: done at cycle %0d, expected %0d (fall at %0d)",
                 d, e.cyc, exp_cyc, fall);
      end
      vectors++;
      if (e.data !== data) begin
        miscompares++;
        $display("FAIL frame_data dut%0d: got %h, expected %h", d, e.data, data);
      end
      vectors++;
      if (e.pe !== exp_pe) begin
        miscompares++;
        $display("FAIL frame_parity dut%0d data=%h pbit=%b: got %b, expected %b", d, data, pbit, e.pe, exp_pe);
      end
      vectors++;
      if (e.fe !== exp_fe) begin
        miscompares++;
        $display("FAIL frame_stop dut%0d stops=%b: got %b, expected %b", d, stops, e.fe, exp_fe);
      end
      vectors++;
      if (e.flag !== 1'b0) begin
        miscompares++;
        $display("FAIL frame_flag dut%0d: rx_flag=%b during done, expected 0", d, e.flag);
      end
    end
    vectors++;
    if (pending(d) != 0) begin
      miscompares++;
      $display("FAIL frame_single dut%0d: %0d extra done pulses, expected 0", d, pending(d));
    end
    last_data[d] = data;
  endtask

  task automatic test_basic();
    test_frame(0, 8'h55, 1'b0, 2'b11, 20);
  endtask

  task automatic test_parity();
    test_frame(1, 8'hA3, 1'b1, 2'b11, 20);
    test_frame(1, 8'hA3, 1'b0, 2'b11, 20);
    test_frame(3, 8'hA3, 1'b1, 2'b11, 20);
    test_frame(3, 8'hA3, 1'b0, 2'b11, 20);
  endtask

  task automatic test_stop2();
    test_frame(2, 8'h3C, 1'b0, 2'b01, 20);
    test_frame(2, 8'h3C, 1'b0, 2'b10, 20);
    test_frame(2, 8'hC3, 1'b0, 2'b11, 20);
  endtask

  task automatic test_glitch();
    logic saw;
    rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd[0] = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (flag[0] === 1'b1) saw = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (saw !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_flag_rise: rx_flag high seen=%b, expected 1", saw);
    end
    vectors++;
    if (flag[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_flag_fall: rx_flag=%b, expected 0", flag[0]);
    end
    vectors++;
    if (pending(0) != 0) begin
      miscompares++;
      $display("FAIL glitch_done: %0d done pulses, expected 0", pending(0));
    end
    vectors++;
    if (dout[0] !== last_data[0]) begin
      miscompares++;
      $display("FAIL glitch_data: uart_data=%h, expected %h", dout[0], last_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    test_frame(0, 8'h12, 1'b0, 2'b11, 0);
    test_frame(0, 8'hF0, 1'b0, 2'b11, 20);
    test_frame(3, 8'h5A, 1'b1, 2'b11, 0);
    test_frame(3, 8'h0F, 1'b0, 2'b11, 20);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < ND; d++) begin
        logic [1:0] st;
        st[0] = ($urandom_range(0, 3) != 0);
        st[1] = ($urandom_range(0, 3) != 0);
        test_frame(d, 8'($urandom), 1'($urandom), st, $urandom_range(1, 20));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] data = 8'hA5;
    rxd[0] = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd[0] = data[i];
      repeat (BPS) @(negedge clk);
    end
    rxd[0] = data[3];
    repeat (BPS / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({done[0], flag[0], pe[0], fe[0], dout[0]} !== 12'h0) begin
      miscompares++;
      $display("FAIL midreset_state: done=%b flag=%b pe=%b fe=%b data=%h, expected all 0",
               done[0], flag[0], pe[0], fe[0], dout[0]);
    end
    rxd[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    vectors++;
    if (pending(0) != 0) begin
      miscompares++;
      $display("FAIL midreset_done: %0d done pulses after abort, expected 0", pending(0));
    end
    vectors++;
    if (dout[0] !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_hold: uart_data=%h, expected 00", dout[0]);
    end
    evq.delete();
    for (int d = 0; d < ND; d++) last_data[d] = 8'h00;
    test_frame(0, 8'h81, 1'b0, 2'b11, 20);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_glitch();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_recv_cfg.md
UART_RECV_CFG -- requirements
Module: uart_recv_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, line baud rate.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked per frame; legal 1 or 2.
REQ-006 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-007 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 uart_rxd  input  1  asynchronous serial line, idle high.
REQ-009 uart_done  output  1  one-cycle pulse on frame completion.
REQ-010 uart_data  output  DATA_BITS  received word, LSB first on line; held between pulses.
REQ-011 rx_flag  output  1  high while a frame is in progress (state not IDLE).
REQ-012 parity_err  output  1  parity mismatch of last frame; 0 when PARITY=0.
REQ-013 frame_err  output  1  any sampled stop bit low in last frame.

Function
REQ-014 BPS_CNT = CLK_FREQ/UART_BPS (integer division); SHALL be >= 2, else elaboration fails; illegal DATA_BITS, PARITY, STOP_BITS also fail elaboration.
REQ-015 uart_rxd passes through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rxd_s.
REQ-016 States: IDLE, START, DATA, PAR, STOP; PAR skipped when PARITY=0.
REQ-017 IDLE -> START on falling edge of rxd_s (previous 1, current 0); clk_cnt=0 in the first START cycle.
REQ-018 In every non-IDLE state clk_cnt counts 0..BPS_CNT-1; the bit is sampled when clk_cnt == BPS_CNT/2; state/bit advance when clk_cnt == BPS_CNT-1, then clk_cnt wraps to 0.
REQ-019 START: sample of 1 -> false start, return to IDLE in next cycle, no uart_done, outputs unchanged.
REQ-020 DATA: bit_cnt 0..DATA_BITS-1, sample shifted into shift register LSB first; after bit DATA_BITS-1 go to PAR or STOP.
REQ-021 PAR: expected bit = XOR of data bits for even, inverted for odd; mismatch recorded.
REQ-022 STOP: STOP_BITS stop samples; at the sample point of the final stop bit state goes to IDLE immediately (no wait to bit end), allowing a new start edge half a bit later.
REQ-023 Cycle after final stop sample: uart_done=1 for exactly one cycle; uart_data, parity_err, frame_err updated in that same cycle and held until next uart_done.
REQ-024 Frames with errors still pulse uart_done and update uart_data.
REQ-025 rx_flag=1 from first START cycle to final stop sample inclusive.
REQ-026 Line low during IDLE without a preceding high (e.g. break) SHALL NOT start a frame until rxd_s returns high then falls.
REQ-027 For DATA_BITS<9 no unused bits exist in uart_data; width equals DATA_BITS.

Reset
REQ-028 sys_rst_n low asynchronously forces: state IDLE, counters 0, synchronizer 1, uart_done 0, uart_data 0, rx_flag 0, parity_err 0, frame_err 0.
REQ-029 Reset mid-frame aborts the frame; no uart_done after release; next frame needs a fresh falling edge.

Verification (CLK_FREQ=16, UART_BPS=1, BPS_CNT=16)
REQ-030 8N1, send 0x55 -> one uart_done pulse, uart_data=0x55, parity_err=0, frame_err=0, done 2+8 samples... exactly 1 cycle after stop sample.
REQ-031 DATA_BITS=8, PARITY=2, send 0xA3 with parity bit 1 -> uart_data=0xA3, parity_err=1; resend with parity 0 -> parity_err=0.
REQ-032 STOP_BITS=2, send 0x3C with second stop bit 0 -> uart_data=0x3C, frame_err=1.
REQ-033 Low glitch of 4 clocks on idle line -> rx_flag pulses high then low, no uart_done, uart_data unchanged.
REQ-034 Two frames 0x12, 0xF0 back-to-back with zero idle -> two uart_done pulses, values 0x12 then 0xF0, no errors.
REQ-035 Assert sys_rst_n during DATA bit 3 -> all outputs 0 immediately; after release, frame 0x81 -> uart_data=0x81.
